// File: rtl/streamcipher_lfsr.sv
// Word-parallel LFSR stream cipher with valid/ready handshakes on both sides.
// Optional debug port ks_out is enabled by defining STREAMCIPHER_KS_OUT_EN.
module streamcipher_lfsr #(
    parameter int                 KEY_W  = 16,
    parameter int                 DATA_W = 8,
    parameter logic [KEY_W-1:0]   TAPS   = 16'hB400,
    parameter int                 CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              keyed,
    output logic [CNT_W-1:0]  word_cnt
`ifdef STREAMCIPHER_KS_OUT_EN
    ,
    output logic [DATA_W-1:0] ks_out
`endif
);

    typedef enum logic {UNKEYED = 1'b0, KEYED = 1'b1} state_t;

    state_t              state_r, state_s;
    logic [KEY_W-1:0]    lfsr_r, lfsr_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                out_valid_r, out_valid_s;
    logic [DATA_W-1:0]   out_data_r, out_data_s;
    logic [DATA_W-1:0]   ks_s;
    logic [KEY_W-1:0]    lfsr_adv_s;
    logic [KEY_W-1:0]    seed_s;
    logic                accept_s;
`ifdef STREAMCIPHER_KS_OUT_EN
    logic [DATA_W-1:0]   ks_r, ks_next_s;
`endif

    function automatic logic fb_parity(input logic [KEY_W-1:0] s);
        return ^(s & TAPS);
    endfunction

    // DATA_W single steps unrolled; keystream collected MSB first.
    function automatic logic [DATA_W+KEY_W-1:0] lfsr_advance(input logic [KEY_W-1:0] s);
        logic [KEY_W-1:0]  st;
        logic [DATA_W-1:0] ks;
        st = s;
        ks = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ks = (ks << 1) | DATA_W'(st[KEY_W-1]);
            st = {st[KEY_W-2:0], fb_parity(st)};
        end
        return {ks, st};
    endfunction

    // Keystream word and post-advance LFSR state for the current seed state
    always_comb begin
        {ks_s, lfsr_adv_s} = lfsr_advance(lfsr_r);
    end

    // An all-zero key would lock the LFSR, so substitute seed 1
    assign seed_s   = (key_in == '0) ? {{(KEY_W-1){1'b0}}, 1'b1} : key_in;
    assign keyed    = (state_r == KEYED);
    assign in_ready = keyed & ~key_load & (~out_valid_r | out_ready);
    assign accept_s = in_valid & in_ready;

    // Key-state next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            UNKEYED: begin
                if (key_load) begin
                    state_s = KEYED;
                end else begin
                    state_s = UNKEYED;
                end
            end
            KEYED:   state_s = KEYED;
            default: state_s = UNKEYED;
        endcase
    end

    // Datapath next-state: key load beats accept; a held output survives a reload
    always_comb begin
        lfsr_s      = lfsr_r;
        cnt_s       = cnt_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
`ifdef STREAMCIPHER_KS_OUT_EN
        ks_next_s   = ks_r;
`endif
        if (key_load) begin
            lfsr_s = seed_s;
            cnt_s  = '0;
            if (out_valid_r && out_ready) begin
                out_valid_s = 1'b0;
            end else begin
                out_valid_s = out_valid_r;
            end
        end else if (accept_s) begin
            lfsr_s      = lfsr_adv_s;
            cnt_s       = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            out_valid_s = 1'b1;
            out_data_s  = in_data ^ ks_s;
`ifdef STREAMCIPHER_KS_OUT_EN
            ks_next_s   = ks_s;
`endif
        end else if (out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= UNKEYED;
            lfsr_r      <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
`ifdef STREAMCIPHER_KS_OUT_EN
            ks_r        <= '0;
`endif
        end else begin
            state_r     <= state_s;
            lfsr_r      <= lfsr_s;
            cnt_r       <= cnt_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
`ifdef STREAMCIPHER_KS_OUT_EN
            ks_r        <= ks_next_s;
`endif
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign word_cnt  = cnt_r;
`ifdef STREAMCIPHER_KS_OUT_EN
    assign ks_out    = ks_r;
`endif

endmodule

// File: tb/tb_streamcipher_lfsr.sv
// Directed bench for streamcipher_lfsr with KEY_W=8, DATA_W=8, TAPS=8'hB8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_streamcipher_lfsr;

    logic        clk;
    logic        reset;
    logic        key_load;
    logic [7:0]  key_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        keyed;
    logic [15:0] word_cnt;
`ifdef STREAMCIPHER_KS_OUT_EN
    logic [7:0]  ks_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    streamcipher_lfsr #(
        .KEY_W(8), .DATA_W(8), .TAPS(8'hB8), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .keyed(keyed), .word_cnt(word_cnt)
`ifdef STREAMCIPHER_KS_OUT_EN
        , .ks_out(ks_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        reload;
        logic [7:0]  key;
        logic [7:0]  din;
        logic [7:0]  dout;
        logic [15:0] cnt;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] pt[8];
    logic [7:0] src[8];
    logic [7:0] got[8];
    logic [7:0] ct_ref[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_key(input logic [7:0] k);
        @(negedge clk);
        key_load = 1'b1;
        key_in   = k;
        @(negedge clk);
        key_load = 1'b0;
        check("keyed_after_load", {31'd0, keyed}, 32'd1);
        check("cnt_after_load", {16'd0, word_cnt}, 32'd0);
    endtask

    // Streams src[0..7] back to back; optionally stalls the sink for 5 cycles after word stall_after
    task automatic run_stream(input int stall_after);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = src[0];
        for (int i = 0; i < 8; i++) begin
            #1;
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            got[i] = out_data;
            check("stream_out_valid", {31'd0, out_valid}, 32'd1);
            if (i < 7) begin
                in_data = src[i+1];
            end else begin
                in_valid = 1'b0;
            end
            if (i == stall_after) begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    @(negedge clk);
                    check("stall_out_data", {24'd0, out_data}, {24'd0, got[i]});
                    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_word_cnt", {16'd0, word_cnt}, i + 1);
                end
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; key_load = 1'b0; key_in = 8'h00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;

        pt = '{8'h49, 8'h53, 8'h4C, 8'h20, 8'h55, 8'h46, 8'h4D, 8'h47};
        // Keystream from F0: F0, BC, 68; from seed 1: 01, 1C
        vecs[0] = '{1'b1, 8'hF0, 8'h49, 8'hB9, 16'd1};
        vecs[1] = '{1'b0, 8'hF0, 8'h53, 8'hEF, 16'd2};
        vecs[2] = '{1'b0, 8'hF0, 8'h4C, 8'h24, 16'd3};
        vecs[3] = '{1'b1, 8'h00, 8'h00, 8'h01, 16'd1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h1C, 16'd2};
        vecs[5] = '{1'b1, 8'h0F, 8'h00, 8'h0F, 16'd1};
        vecs[6] = '{1'b1, 8'hF0, 8'h49, 8'hB9, 16'd1};

        // Reset held
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_keyed", {31'd0, keyed}, 32'd0);
        check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);

        // Unkeyed: nothing accepted
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("unkeyed_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            check("unkeyed_out_valid", {31'd0, out_valid}, 32'd0);
            check("unkeyed_word_cnt", {16'd0, word_cnt}, 32'd0);
        end
        in_valid = 1'b0;

        // Table-driven single words
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].reload) load_key(vecs[v].key);
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vecs[v].din;
            #1;
            for (int w = 0; w < 20 && !in_ready; w++) begin
                @(negedge clk);
                #1;
            end
            check("vec_accept", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            check("vec_out_valid", {31'd0, out_valid}, 32'd1);
            check("vec_out_data", {24'd0, out_data}, {24'd0, vecs[v].dout});
            check("vec_word_cnt", {16'd0, word_cnt}, {16'd0, vecs[v].cnt});
`ifdef STREAMCIPHER_KS_OUT_EN
            check("vec_ks_out", {24'd0, ks_out}, {24'd0, vecs[v].dout ^ vecs[v].din});
`endif
        end

        // Encrypt stream back to back
        load_key(8'hF0);
        src = pt;
        run_stream(-1);
        ct_ref = got;
        check("enc_word0", {24'd0, ct_ref[0]}, 32'hB9);
        check("enc_word1", {24'd0, ct_ref[1]}, 32'hEF);
        check("enc_word2", {24'd0, ct_ref[2]}, 32'h24);
        check("enc_cnt", {16'd0, word_cnt}, 32'd8);

        // Decrypt returns the plaintext
        load_key(8'hF0);
        src = ct_ref;
        run_stream(-1);
        for (int i = 0; i < 8; i++) check("dec_word", {24'd0, got[i]}, {24'd0, pt[i]});
        check("dec_cnt", {16'd0, word_cnt}, 32'd8);

        // Stalled run matches the unstalled ciphertext
        load_key(8'hF0);
        src = pt;
        run_stream(2);
        for (int i = 0; i < 8; i++) check("stall_word", {24'd0, got[i]}, {24'd0, ct_ref[i]});

        // key_load together with in_valid
        @(negedge clk);
        key_load = 1'b1;
        key_in   = 8'h0F;
        in_valid = 1'b1;
        in_data  = 8'h00;
        #1;
        check("kl_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        key_load = 1'b0;
        check("kl_no_accept", {31'd0, out_valid}, 32'd0);
        check("kl_cnt_zero", {16'd0, word_cnt}, 32'd0);
        #1;
        check("kl_in_ready_after", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("kl_out_valid", {31'd0, out_valid}, 32'd1);
        check("kl_out_data", {24'd0, out_data}, 32'h0F);
        check("kl_word_cnt", {16'd0, word_cnt}, 32'd1);

        // Reset with a pending output drops it asynchronously
        out_ready = 1'b0;
        @(negedge clk);
        check("pend_out_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_keyed", {31'd0, keyed}, 32'd0);
        check("midrst_out_data", {24'd0, out_data}, 32'd0);
        check("midrst_word_cnt", {16'd0, word_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
